// File: rtl/shift_seq_unit.sv
// Multi-cycle shifter: loads an operand, then shifts it one bit per enabled cycle.
// Define SHIFT_SEQ_ROTATE_EN to make mode 2'b11 rotate left; otherwise 2'b11 acts as LSL.
module shift_seq_unit #(
    parameter  int WIDTH = 32,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] amt,
    input  logic [1:0]       mode,
    input  logic             cin,
    input  logic             en,
    output logic [WIDTH-1:0] b,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // One shift step; result is {bit shifted out, new value}.
    function automatic logic [WIDTH:0] shift_step(
        input logic [WIDTH-1:0] v,
        input logic [1:0]       m,
        input logic             c
    );
        case (m)
            2'b00: shift_step = {v[WIDTH-1], v[WIDTH-2:0], c};
            2'b01: shift_step = {v[0], c, v[WIDTH-1:1]};
            2'b10: shift_step = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
`ifdef SHIFT_SEQ_ROTATE_EN
            2'b11: shift_step = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
`else
            2'b11: shift_step = {v[WIDTH-1], v[WIDTH-2:0], c};
`endif
            default: shift_step = {v[WIDTH-1], v[WIDTH-2:0], c};
        endcase
    endfunction

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic             cout_q, cout_d;
    logic [1:0]       mode_q, mode_d;
    logic             cin_q, cin_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   step_s;

    assign step_s = shift_step(b_q, mode_q, cin_q);

    // Next-state logic: load in IDLE/DONE, step while enabled in SHIFT.
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        count_d = count_q;
        cout_d  = cout_q;
        mode_d  = mode_q;
        cin_d   = cin_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    b_d     = a;
                    count_d = amt;
                    mode_d  = mode;
                    cin_d   = cin;
                    cout_d  = 1'b0;
                    state_d = (amt != {AMT_W{1'b0}}) ? SHIFT : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (en) begin
                    b_d     = step_s[WIDTH-1:0];
                    cout_d  = step_s[WIDTH];
                    count_d = count_q - AMT_W'(1);
                    if (count_q == AMT_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            b_q     <= {WIDTH{1'b0}};
            count_q <= {AMT_W{1'b0}};
            cout_q  <= 1'b0;
            mode_q  <= 2'b00;
            cin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            count_q <= count_d;
            cout_q  <= cout_d;
            mode_q  <= mode_d;
            cin_q   <= cin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign b    = b_q;
    assign cout = cout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
